// File: rtl/sdram_tester_pkg.sv
// Shared types and helpers for the SDRAM Avalon pattern tester.
// Holds the run FSM state type, counter widths and the test pattern.
package sdram_tester_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD,
      DRAIN,
      DONE
   } state_t;

   localparam int PEND_W = 4;
   localparam int ERR_W  = 16;

   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   function automatic logic [15:0] pat(
      input logic [15:0] idx,
      input logic [15:0] seed
   );
      return idx ^ seed;
   endfunction

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sdram_avalon_tester_if.sv
// Avalon-MM bus between the tester (master) and the SDRAM controller slave.
interface sdram_avalon_tester_if #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 16
);

   logic [ADDR_W-1:0] avm_address;
   logic              avm_read;
   logic              avm_write;
   logic [DATA_W-1:0] avm_writedata;
   logic [1:0]        avm_byteenable;
   logic              avm_waitrequest;
   logic [DATA_W-1:0] avm_readdata;
   logic              avm_readdatavalid;

   modport master (
      output avm_address,
      output avm_read,
      output avm_write,
      output avm_writedata,
      output avm_byteenable,
      input  avm_waitrequest,
      input  avm_readdata,
      input  avm_readdatavalid
   );

   modport slave (
      input  avm_address,
      input  avm_read,
      input  avm_write,
      input  avm_writedata,
      input  avm_byteenable,
      output avm_waitrequest,
      output avm_readdata,
      output avm_readdatavalid
   );

endinterface

// File: rtl/sdram_tester_checker.sv
// Read-back checker: walks the expected pattern as responses arrive
// and tracks the error count and the first failing word address.
module sdram_tester_checker
   import sdram_tester_pkg::*;
#(
   parameter int ADDR_W    = 24,
   parameter int DATA_W    = 16,
   parameter int BASE      = 0,
   parameter int NUM_WORDS = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clear,
   input  logic [15:0]       i_seed,
   input  logic              i_rdv,
   input  logic [DATA_W-1:0] i_rdata,
   input  logic              i_pend_zero,
   output logic [ERR_W-1:0]  o_err_count,
   output logic [ADDR_W-1:0] o_first_err_addr,
   output logic              o_j_done
);

   localparam int CNT_W = cnt_w(NUM_WORDS);

   logic [CNT_W-1:0]  r_j;
   logic [ERR_W-1:0]  r_err;
   logic [ADDR_W-1:0] r_first;

   logic [DATA_W-1:0] w_expect;
   logic              w_hit;
   logic              w_miss;
   logic              w_bump;

   assign w_expect = DATA_W'(pat(16'(r_j), i_seed));
   assign w_hit    = i_rdv && !i_pend_zero;
   assign w_miss   = w_hit && (i_rdata != w_expect);
   // A response with nothing outstanding is an error but has no word slot
   assign w_bump   = w_miss || (i_rdv && i_pend_zero);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_j     <= '0;
         r_err   <= '0;
         r_first <= '0;
      end else if (i_clear) begin
         r_j     <= '0;
         r_err   <= '0;
         r_first <= '0;
      end else begin
         if (w_hit) begin
            r_j <= r_j + CNT_W'(1);
         end
         if (w_bump && (r_err != ERR_MAX)) begin
            r_err <= r_err + ERR_W'(1);
         end
         if (w_miss && (r_err == '0)) begin
            r_first <= ADDR_W'(BASE) + ADDR_W'(r_j);
         end
      end
   end

   assign o_err_count      = r_err;
   assign o_first_err_addr = r_first;
   assign o_j_done         = (r_j == CNT_W'(NUM_WORDS));

endmodule

// File: rtl/sdram_avalon_tester.sv
// SDRAM pattern tester: writes (index ^ seed) over a word range,
// reads it back with pipelined reads and reports pass/fail.
module sdram_avalon_tester
   import sdram_tester_pkg::*;
#(
   parameter int ADDR_W    = 24,
   parameter int DATA_W    = 16,
   parameter int BASE      = 0,
   parameter int NUM_WORDS = 1024,
   parameter int MAX_PEND  = 7
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset_n,
   input  logic                  start,
   input  logic [15:0]           seed,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ERR_W-1:0]      err_count,
   output logic [ADDR_W-1:0]     first_err_addr,
   sdram_avalon_tester_if.master avm
);

   localparam int CNT_W = cnt_w(NUM_WORDS);

   localparam logic [CNT_W-1:0]  LAST     = CNT_W'(NUM_WORDS - 1);
   localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE);
   localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

   state_t            r_state;
   logic              r_busy;
   logic              r_done;
   logic              r_read;
   logic              r_write;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [CNT_W-1:0]  r_i;
   logic [PEND_W-1:0] r_pend;
   logic [15:0]       r_seed;

   logic              w_start;
   logic              w_wr_acc;
   logic              w_rd_acc;
   logic              w_pend_zero;
   logic              w_rdv_ok;
   logic              w_rd_more;
   logic              w_j_done;
   logic [CNT_W-1:0]  w_i_inc;
   logic [PEND_W-1:0] w_pend_nx;

   assign w_start     = start && !r_busy;
   assign w_wr_acc    = r_write && !avm.avm_waitrequest;
   assign w_rd_acc    = r_read && !avm.avm_waitrequest;
   assign w_pend_zero = (r_pend == '0);
   assign w_rdv_ok    = avm.avm_readdatavalid && !w_pend_zero;
   assign w_i_inc     = r_i + CNT_W'(1);

   assign w_pend_nx = r_pend
                    + PEND_W'(w_rd_acc)
                    - PEND_W'(w_rdv_ok);

   // Looking at next-cycle pend keeps one read per cycle without overshoot
   assign w_rd_more = (w_pend_nx < PEND_MAX);

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_read  <= 1'b0;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_i     <= '0;
         r_pend  <= '0;
         r_seed  <= '0;
      end else begin
         r_pend <= w_pend_nx;
         unique case (r_state)
            IDLE, DONE: begin
               if (w_start) begin
                  r_state <= WR;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_seed  <= seed;
                  r_i     <= '0;
                  r_write <= 1'b1;
                  r_addr  <= BASE_A;
                  r_wdata <= DATA_W'(pat(16'h0000, seed));
               end
            end
            WR: begin
               if (w_wr_acc) begin
                  if (r_i == LAST) begin
                     r_state <= RD;
                     r_write <= 1'b0;
                     r_read  <= 1'b1;
                     r_addr  <= BASE_A;
                     r_i     <= '0;
                  end else begin
                     r_i     <= w_i_inc;
                     r_addr  <= BASE_A + ADDR_W'(w_i_inc);
                     r_wdata <= DATA_W'(pat(16'(w_i_inc), r_seed));
                  end
               end
            end
            RD: begin
               if (w_rd_acc && (r_i == LAST)) begin
                  r_state <= DRAIN;
                  r_read  <= 1'b0;
               end else begin
                  r_read <= w_rd_more;
                  if (w_rd_acc) begin
                     r_i    <= w_i_inc;
                     r_addr <= BASE_A + ADDR_W'(w_i_inc);
                  end
               end
            end
            DRAIN: begin
               if (w_j_done && w_pend_zero) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   sdram_tester_checker #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .BASE      (BASE),
      .NUM_WORDS (NUM_WORDS)
   ) u_chk (
      .clk              (clk_clk),
      .rst_n            (reset_reset_n),
      .i_clear          (w_start),
      .i_seed           (r_seed),
      .i_rdv            (avm.avm_readdatavalid),
      .i_rdata          (avm.avm_readdata),
      .i_pend_zero      (w_pend_zero),
      .o_err_count      (err_count),
      .o_first_err_addr (first_err_addr),
      .o_j_done         (w_j_done)
   );

   assign avm.avm_address    = r_addr;
   assign avm.avm_read       = r_read;
   assign avm.avm_write      = r_write;
   assign avm.avm_writedata  = r_wdata;
   assign avm.avm_byteenable = 2'b11;

   assign busy = r_busy;
   assign done = r_done;
   assign pass = r_done && (err_count == '0);

endmodule

// File: tb/tb_sdram_avalon_tester.sv
// Bench for sdram_avalon_tester: memory slave model, bus scoreboards
// and a result scoreboard fed by a high-level model of each run.
module tb_sdram_avalon_tester;

   localparam int ADDR_W   = 24;
   localparam int DATA_W   = 16;
   localparam int BASE     = 0;
   localparam int NW       = 8;
   localparam int MAX_PEND = 7;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [15:0]       seed;
   logic              busy;
   logic              done;
   logic              pass;
   logic [15:0]       err_count;
   logic [ADDR_W-1:0] first_err_addr;

   sdram_avalon_tester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) avm ();

   sdram_avalon_tester #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .BASE      (BASE),
      .NUM_WORDS (NW),
      .MAX_PEND  (MAX_PEND)
   ) dut (
      .clk_clk        (clk),
      .reset_reset_n  (rst_n),
      .start          (start),
      .seed           (seed),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .first_err_addr (first_err_addr),
      .avm            (avm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [15:0]       d;
   } wr_t;

   typedef struct {
      int          due;
      logic [15:0] d;
   } rsp_t;

   typedef struct {
      int err;
      int first;
      bit chk_first;
      bit pass;
   } res_t;

   wr_t               wr_exp[$];
   logic [ADDR_W-1:0] rd_exp[$];
   rsp_t              rsp_q[$];
   res_t              exp_q[$];

   logic [15:0] mem   [NW];
   logic [15:0] cor_x [NW];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0, outstanding = 0, max_out = 0, rsp_cnt = 0, wr_high = 0;
   int lat = 1, rand_pct = 0, stall_idx = -1, stall_len = 0;
   int stall_cnt = 0, wr_seen = 0;
   bit inject_spur = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Slave model and bus scoreboard: decides at negedge what the next posedge accepts
   initial begin : bus
      bit                p_st;
      logic              p_rd, p_wr;
      logic [ADDR_W-1:0] p_a;
      logic [15:0]       p_d;
      bit                w;
      bit                req;
      int                idx;
      wr_t               e;
      rsp_t              r;
      p_st = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            rsp_q.delete();
            outstanding = 0;
            p_st = 0;
            avm.avm_waitrequest   = 1'b0;
            avm.avm_readdatavalid = 1'b0;
            avm.avm_readdata      = '0;
         end else begin
            req = avm.avm_read || avm.avm_write;
            if (p_st) begin
               chk("hold_stall",
                   {avm.avm_read, avm.avm_write, avm.avm_address, avm.avm_writedata}
                   == {p_rd, p_wr, p_a, p_d}, 1);
            end
            if (outstanding >= MAX_PEND) chk("read_low_at_max", avm.avm_read, 0);
            if (avm.avm_write) wr_high++;
            w = 0;
            if (avm.avm_write && wr_seen == stall_idx && stall_cnt < stall_len) begin
               w = 1;
               stall_cnt++;
            end else if (req && rand_pct > 0 && $urandom_range(99) < rand_pct) begin
               w = 1;
            end
            avm.avm_waitrequest = w;
            p_st = req && w;
            p_rd = avm.avm_read;
            p_wr = avm.avm_write;
            p_a  = avm.avm_address;
            p_d  = avm.avm_writedata;
            if (req && !w) begin
               chk("byteenable", avm.avm_byteenable, 3);
               idx = int'(avm.avm_address) - BASE;
               if (avm.avm_write) begin
                  chk("no_write_while_pending", outstanding, 0);
                  chk("write_expected", wr_exp.size() != 0, 1);
                  if (wr_exp.size() != 0) begin
                     e = wr_exp.pop_front();
                     chk("wr_addr", avm.avm_address, e.a);
                     chk("wr_data", avm.avm_writedata, e.d);
                  end
                  if (idx >= 0 && idx < NW) mem[idx] = avm.avm_writedata;
                  wr_seen++;
               end else begin
                  chk("read_expected", rd_exp.size() != 0, 1);
                  if (rd_exp.size() != 0) chk("rd_addr", avm.avm_address, rd_exp.pop_front());
                  r.due = cyc + lat;
                  if (idx >= 0 && idx < NW) r.d = mem[idx] ^ cor_x[idx];
                  else r.d = 16'hDEAD;
                  rsp_q.push_back(r);
                  outstanding++;
               end
            end
            avm.avm_readdatavalid = 1'b0;
            if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
               r = rsp_q.pop_front();
               avm.avm_readdatavalid = 1'b1;
               avm.avm_readdata      = r.d;
               outstanding--;
               rsp_cnt++;
            end else if (inject_spur && outstanding == 0) begin
               avm.avm_readdatavalid = 1'b1;
               avm.avm_readdata      = 16'h0BAD;
               inject_spur = 0;
            end
            if (outstanding > max_out) max_out = outstanding;
         end
      end
   end

   // Result scoreboard: pops the modelled outcome whenever done rises
   initial begin : done_mon
      bit   dq;
      res_t e;
      dq = 0;
      forever begin
         @(negedge clk);
         if (done && !dq) begin
            chk("done_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("err_count", err_count, e.err);
               if (e.chk_first) chk("first_err_addr", first_err_addr, e.first);
               chk("pass", pass, e.pass);
               chk("busy_at_done", busy, 0);
               chk("rsp_before_done", rsp_cnt, NW);
            end
         end
         dq = done;
      end
   end

   task automatic pulse_start(input logic [15:0] s);
      seed  = s;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic clr_knobs();
      lat = 1;
      rand_pct = 0;
      stall_idx = -1;
      stall_len = 0;
      inject_spur = 0;
      for (int i = 0; i < NW; i++) cor_x[i] = '0;
   endtask

   task automatic chk_reset(input string t);
      chk({t, "_busy"}, busy, 0);
      chk({t, "_done"}, done, 0);
      chk({t, "_pass"}, pass, 0);
      chk({t, "_err"}, err_count, 0);
      chk({t, "_first"}, first_err_addr, 0);
      chk({t, "_read"}, avm.avm_read, 0);
      chk({t, "_write"}, avm.avm_write, 0);
      chk({t, "_addr"}, avm.avm_address, 0);
      chk({t, "_wdata"}, avm.avm_writedata, 0);
      chk({t, "_be"}, avm.avm_byteenable, 3);
   endtask

   task automatic push_traffic(input logic [15:0] s);
      wr_t e;
      for (int i = 0; i < NW; i++) begin
         e.a = ADDR_W'(BASE + i);
         e.d = 16'(i) ^ s;
         wr_exp.push_back(e);
         rd_exp.push_back(ADDR_W'(BASE + i));
      end
   endtask

   task automatic run(input logic [15:0] s, input bit spur, input bit restart);
      res_t e;
      int   k;
      int   nerr;
      int   first;
      nerr  = 0;
      first = -1;
      push_traffic(s);
      for (int i = 0; i < NW; i++) begin
         if (cor_x[i] != 0) begin
            nerr++;
            if (first < 0) first = BASE + i;
         end
      end
      if (spur) nerr++;
      e.err       = nerr;
      e.first     = (first < 0) ? 0 : first;
      e.chk_first = !spur;
      e.pass      = (nerr == 0);
      exp_q.push_back(e);
      wr_high = 0;
      rsp_cnt = 0;
      max_out = 0;
      stall_cnt = 0;
      wr_seen = 0;
      pulse_start(s);
      chk("start_latency", avm.avm_write, 1);
      if (restart) begin
         pulse_start(~s);
         chk("restart_ignored_busy", busy, 1);
      end
      if (spur) inject_spur = 1;
      k = 0;
      while (!done && k < 4000) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("done_seen", done, 1);
      @(posedge clk);
      #1;
      chk("wr_queue_empty", wr_exp.size(), 0);
      chk("rd_queue_empty", rd_exp.size(), 0);
      chk("pend_bound", max_out <= MAX_PEND, 1);
   endtask

   initial begin : stim
      int k;
      start = 1'b0;
      seed  = '0;
      rst_n = 1'b0;
      avm.avm_waitrequest   = 1'b0;
      avm.avm_readdatavalid = 1'b0;
      avm.avm_readdata      = '0;
      clr_knobs();
      repeat (3) @(posedge clk);
      #1;
      chk_reset("rst");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run(16'hA5A5, 0, 0);
      chk("t1_write_cycles", wr_high, NW);

      clr_knobs();
      stall_idx = 1;
      stall_len = 3;
      run(16'h1234, 0, 0);
      chk("t2_write_cycles", wr_high, NW + 3);
      chk("t2_stalls", stall_cnt, 3);

      clr_knobs();
      lat = 10;
      run(16'h0F0F, 0, 0);
      chk("t3_max_pending", max_out, MAX_PEND);

      clr_knobs();
      cor_x[5] = 16'h0001;
      run(16'hBEEF, 0, 0);

      clr_knobs();
      lat = 10;
      push_traffic(16'h7777);
      wr_seen = 0;
      stall_cnt = 0;
      pulse_start(16'h7777);
      k = 0;
      while (!(avm.avm_read && outstanding == 3) && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("t5_pend3", outstanding, 3);
      rst_n = 1'b0;
      #1;
      chk_reset("abort");
      wr_exp.delete();
      rd_exp.delete();
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clr_knobs();
      lat = 3;
      run(16'hC3C3, 0, 0);

      clr_knobs();
      run(16'h5A5A, 1, 1);

      repeat (8) begin
         clr_knobs();
         lat = $urandom_range(12, 1);
         rand_pct = $urandom_range(40, 0);
         for (int i = 0; i < NW; i++) begin
            if ($urandom_range(7, 0) == 0) cor_x[i] = 16'($urandom_range(65535, 1));
         end
         run(16'($urandom), 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
